uart_tx_controller: RTL and testbench

- Moore/Mealy FSM that sequences the UART TX datapath (queue, shift register, bit counter, parity, output mux) to emit one frame per queued byte: start, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits beside the UART datapath inside the UART peripheral. Consumes its bit-period tick and status flags and drives all of its TX control strobes.

---
 rtl/uart_tx_controller.sv | 158 +++++++++++++++
 tb/tb_uart_tx_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// UART TX frame sequencer: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the break_req input and a BREAK state that holds the line low.
module uart_tx_controller #(
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       bit_tick,
  input  logic                       tx_queue_empty,
  input  logic                       tx_bits_cnt_top,
  input  logic                       parity_en,
  input  logic                       double_stop,
  input  logic                       irq_en_tx_empty,
`ifdef UART_TX_BREAK_EN
  input  logic                       break_req,
`endif
  output logic                       tx_queue_re,
  output logic                       tx_shift_reg_we,
  output logic                       tx_shift_reg_se,
  output logic                       tx_bits_cnt_en,
  output logic                       tx_bits_cnt_reset,
  output logic                       tx_parity_we,
  output logic                       tx_parity_reset,
  output logic [1:0]                 tx_out_sel,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       irq_tx_empty,
  output logic [FRAME_CNT_WIDTH-1:0] frames_sent,
  output logic [2:0]                 state_dbg
);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;
`endif

  state_t                     state_q, state_d;
  logic                       parity_en_q, double_stop_q;
  logic [FRAME_CNT_WIDTH-1:0] frames_sent_q;
  logic                       load_ok, load, end_frame;

  assign load_ok = enable && !tx_queue_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      parity_en_q   <= 1'b0;
      double_stop_q <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q <= state_d;
      // Frame format is frozen at load time; later config changes wait for the next frame.
      if (load) begin
        parity_en_q   <= parity_en;
        double_stop_q <= double_stop;
      end
      if (end_frame) frames_sent_q <= frames_sent_q + FRAME_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d           = state_q;
    tx_queue_re       = 1'b0;
    tx_shift_reg_we   = 1'b0;
    tx_shift_reg_se   = 1'b0;
    tx_bits_cnt_en    = 1'b0;
    tx_bits_cnt_reset = 1'b0;
    tx_parity_we      = 1'b0;
    tx_parity_reset   = 1'b0;
    tx_out_sel        = 2'b01;
    frame_done        = 1'b0;
    load              = 1'b0;
    end_frame         = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (bit_tick) begin
`ifdef UART_TX_BREAK_EN
            if (break_req) state_d = S_BREAK;
            else if (load_ok) load = 1'b1;
`else
            if (load_ok) load = 1'b1;
`endif
          end
        end
        S_START: begin
          tx_out_sel = 2'b00;
          if (bit_tick) state_d = S_DATA;
        end
        S_DATA: begin
          tx_out_sel = 2'b10;
          if (bit_tick) begin
            tx_parity_we    = 1'b1;
            tx_shift_reg_se = 1'b1;
            tx_bits_cnt_en  = 1'b1;
            if (tx_bits_cnt_top) state_d = parity_en_q ? S_PARITY : S_STOP1;
          end
        end
        S_PARITY: begin
          tx_out_sel = 2'b11;
          if (bit_tick) state_d = S_STOP1;
        end
        S_STOP1: begin
          if (bit_tick) begin
            if (double_stop_q) state_d = S_STOP2;
            else end_frame = 1'b1;
          end
        end
        S_STOP2: begin
          if (bit_tick) end_frame = 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          tx_out_sel = 2'b00;
          if (bit_tick && !break_req) state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
      // Back-to-back frames: the last stop tick reloads directly into START.
      if (end_frame) begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
        load       = load_ok;
      end
      if (load) begin
        tx_queue_re       = 1'b1;
        tx_shift_reg_we   = 1'b1;
        tx_bits_cnt_reset = 1'b1;
        tx_parity_reset   = 1'b1;
        state_d           = S_START;
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign irq_tx_empty = irq_en_tx_empty && tx_queue_empty && (state_q == S_IDLE);
  assign frames_sent  = frames_sent_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: FIFO/datapath stand-in, bit-period frame model, per-cycle compare.
module tb_uart_tx_controller;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          bit_tick = 1'b0;
  logic          tx_queue_empty = 1'b1;
  logic          tx_bits_cnt_top = 1'b0;
  logic          parity_en = 1'b0;
  logic          double_stop = 1'b0;
  logic          irq_en_tx_empty = 1'b0;
  logic          tx_queue_re, tx_shift_reg_we, tx_shift_reg_se, tx_bits_cnt_en;
  logic          tx_bits_cnt_reset, tx_parity_we, tx_parity_reset;
  logic          busy, frame_done, irq_tx_empty;
  logic [1:0]    tx_out_sel;
  logic [FW-1:0] frames_sent;
  logic [2:0]    state_dbg;
  logic          brk;
`ifdef UART_TX_BREAK_EN
  logic          break_req = 1'b0;
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  // stimulus-side FIFO and datapath stand-in
  logic [7:0] fifo_q[$];
  logic [7:0] dp_sr = 8'h00;
  int         dp_cnt = 0;
  logic       dp_par = 1'b0;
  int         tick_div = 16;
  int         tick_cnt = 0;
  int         data_bits = 8;

  // frame model: expected line level for every remaining bit period of the current frame
  logic [7:0] mfifo[$];
  logic       mline_q[$];
  int         m_frames = 0;
  logic       m_break = 1'b0;

  int         n_checks = 0;
  int         n_fail = 0;
  int         re_cnt = 0;
  int         fd_cnt = 0;
  logic       rec_q[$];
  logic       chk_on = 1'b0;
  logic [11:0] v;

  uart_tx_controller #(.FRAME_CNT_WIDTH(FW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_tick(bit_tick),
    .tx_queue_empty(tx_queue_empty), .tx_bits_cnt_top(tx_bits_cnt_top),
    .parity_en(parity_en), .double_stop(double_stop), .irq_en_tx_empty(irq_en_tx_empty),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx_queue_re(tx_queue_re), .tx_shift_reg_we(tx_shift_reg_we),
    .tx_shift_reg_se(tx_shift_reg_se), .tx_bits_cnt_en(tx_bits_cnt_en),
    .tx_bits_cnt_reset(tx_bits_cnt_reset), .tx_parity_we(tx_parity_we),
    .tx_parity_reset(tx_parity_reset), .tx_out_sel(tx_out_sel), .busy(busy),
    .frame_done(frame_done), .irq_tx_empty(irq_tx_empty), .frames_sent(frames_sent),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame as line levels, bit 0 first on the wire; unused upper bits read as idle 1.
  function automatic logic [11:0] frame_vec(input logic [7:0] b, input int nb, input logic pe);
    logic [11:0] f;
    logic        p;
    int          k;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    k = 1;
    for (int i = 0; i < nb; i++) begin
      f[k] = b[i];
      p ^= b[i];
      k++;
    end
    if (pe) f[k] = p;
    return f;
  endfunction

  function automatic int frame_len(input int nb, input logic pe, input logic ds);
    return 2 + nb + (pe ? 1 : 0) + (ds ? 1 : 0);
  endfunction

  function automatic void load_frame(input logic [7:0] b);
    logic [11:0] f;
    int          len;
    f = frame_vec(b, data_bits, parity_en);
    len = frame_len(data_bits, parity_en, double_stop);
    for (int i = 0; i < len; i++) mline_q.push_back(f[i]);
  endfunction

  function automatic logic [11:0] pack_rec();
    logic [11:0] r;
    r = '1;
    for (int i = 0; i < rec_q.size() && i < 12; i++) r[i] = rec_q[i];
    return r;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    mfifo.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mline_q.size() != 0 || m_break || fifo_q.size() != 0 || mfifo.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, state_dbg=%0d busy=%0b", budget, state_dbg, busy);
    end
    @(negedge clk);
    #1;
  endtask

  // ---------------- tick generator and datapath inputs ----------------
  initial forever begin
    @(negedge clk);
    if (tick_cnt >= tick_div - 1) begin
      bit_tick = 1'b1;
      tick_cnt = 0;
    end else begin
      bit_tick = 1'b0;
      tick_cnt++;
    end
    tx_queue_empty  = (fifo_q.size() == 0);
    tx_bits_cnt_top = (dp_cnt == data_bits - 1);
  end

  initial forever begin
    @(posedge clk);
    if (tx_shift_reg_we && fifo_q.size() > 0) dp_sr <= fifo_q[0];
    else if (tx_shift_reg_se) dp_sr <= dp_sr >> 1;
    if (tx_queue_re && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (tx_bits_cnt_reset) dp_cnt <= 0;
    else if (tx_bits_cnt_en) dp_cnt <= dp_cnt + 1;
    if (tx_parity_reset) dp_par <= 1'b0;
    else if (tx_parity_we) dp_par <= dp_par ^ dp_sr[0];
  end

  // ---------------- reference model (bit-period granularity) ----------------
  initial forever begin
    @(posedge clk);
    if (reset) begin
      mline_q.delete();
      m_frames = 0;
      m_break = 1'b0;
    end else if (bit_tick) begin
      if (m_break) begin
        if (!brk) m_break = 1'b0;
      end else if (mline_q.size() == 0 && brk) begin
        m_break = 1'b1;
      end else begin
        if (mline_q.size() > 0) begin
          void'(mline_q.pop_front());
          if (mline_q.size() == 0) m_frames++;
        end
        if (mline_q.size() == 0 && enable && !tx_queue_empty && mfifo.size() > 0)
          load_frame(mfifo.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    int   sz;
    logic line, e_line, e_busy, e_fd, e_re, e_irq;
    @(negedge clk);
    #3;
    if (chk_on && !reset) begin
      sz = mline_q.size();
      case (tx_out_sel)
        2'b00:   line = 1'b0;
        2'b01:   line = 1'b1;
        2'b10:   line = dp_sr[0];
        default: line = dp_par;
      endcase
      e_line = m_break ? 1'b0 : (sz > 0 ? mline_q[0] : 1'b1);
      e_busy = m_break || sz > 0;
      e_fd   = bit_tick && !m_break && sz == 1;
      e_re   = bit_tick && !m_break && !(sz == 0 && brk) && sz <= 1 && enable && !tx_queue_empty;
      e_irq  = irq_en_tx_empty && tx_queue_empty && sz == 0 && !m_break;
      chk("line", 32'(line), 32'(e_line));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("tx_queue_re", 32'(tx_queue_re), 32'(e_re));
      chk("irq_tx_empty", 32'(irq_tx_empty), 32'(e_irq));
      chk("frames_sent", 32'(frames_sent), 32'(FW'(m_frames)));
      if (bit_tick && busy) rec_q.push_back(line);
      if (tx_queue_re) re_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_sel", 32'(tx_out_sel), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_queue_re", 32'(tx_queue_re), 32'h0);
    chk("rst_shift_we", 32'(tx_shift_reg_we), 32'h0);
    chk("rst_frames_sent", 32'(frames_sent), 32'h0);
    // hand-computed frames pin the model's frame builder
    chk("model_a5", 32'(frame_vec(8'hA5, 8, 1'b0)), 32'hF4A);
    chk("model_07p", 32'(frame_vec(8'h07, 8, 1'b1)), 32'hE0E);
    chk("model_1f5", 32'(frame_vec(8'h1F, 5, 1'b0)), 32'hFFE);
    chk("model_len", 32'(frame_len(8, 1'b1, 1'b1)), 32'd12);
    reset = 1'b0;
    chk_on = 1'b1;
    enable = 1'b1;

    // 0xA5, 8N1, 16-cycle bit period
    rec_q.delete();
    re_cnt = 0;
    fd_cnt = 0;
    push(8'hA5);
    wait_idle(600);
    chk("a5_len", 32'(rec_q.size()), 32'd10);
    chk("a5_bits", 32'(pack_rec()), 32'hF4A);
    chk("a5_frame_done", 32'(fd_cnt), 32'd1);
    chk("a5_pops", 32'(re_cnt), 32'd1);
    chk("a5_frames_sent", 32'(frames_sent), 32'd1);

    // parity: 0x07 -> parity 1, 0x03 -> parity 0
    tick_div = 4;
    parity_en = 1'b1;
    rec_q.delete();
    push(8'h07);
    wait_idle(200);
    chk("p07_len", 32'(rec_q.size()), 32'd11);
    chk("p07_bits", 32'(pack_rec()), 32'hE0E);
    rec_q.delete();
    push(8'h03);
    wait_idle(200);
    chk("p03_len", 32'(rec_q.size()), 32'd11);
    chk("p03_bits", 32'(pack_rec()), 32'hC06);

    // two stop bits, back-to-back frames, irq after the second
    parity_en = 1'b0;
    double_stop = 1'b1;
    irq_en_tx_empty = 1'b1;
    rec_q.delete();
    push(8'h55);
    push(8'hAA);
    wait_idle(300);
    chk("ds_len", 32'(rec_q.size()), 32'd22);
    chk("ds_bits", 32'(pack_rec()), 32'h6AA);
    chk("ds_frames_sent", 32'(frames_sent), 32'd5);
    chk("ds_irq", 32'(irq_tx_empty), 32'h1);

    // 5-bit mode
    double_stop = 1'b0;
    data_bits = 5;
    rec_q.delete();
    push(8'h1F);
    wait_idle(200);
    chk("b5_len", 32'(rec_q.size()), 32'd7);
    chk("b5_bits", 32'(pack_rec()), 32'hFFE);

    // reset while data bit 3 is on the line
    data_bits = 8;
    push(8'h3C);
    begin
      int n = 0;
      while (mline_q.size() != 6 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("rst_reach_data3", 32'(n < 200), 32'h1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_out_sel", 32'(tx_out_sel), 32'h1);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_frames", 32'(frames_sent), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    rec_q.delete();
    push(8'h81);
    wait_idle(200);
    chk("after_rst_len", 32'(rec_q.size()), 32'd10);
    chk("after_rst_bits", 32'(pack_rec()), 32'hF02);
    chk("after_rst_frames", 32'(frames_sent), 32'd1);

    // randomized traffic: config toggled mid-frame, enable gaps
    for (int b = 0; b < 6; b++) begin
      tick_div = $urandom_range(1, 4);
      data_bits = $urandom_range(5, 8);
      irq_en_tx_empty = 1'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) begin
        parity_en = 1'($urandom_range(0, 1));
        double_stop = 1'($urandom_range(0, 1));
        enable = ($urandom_range(0, 3) != 0);
        push(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 25)) @(negedge clk);
        @(negedge clk);
        #1;
      end
      enable = 1'b1;
      wait_idle(3000);
    end

`ifdef UART_TX_BREAK_EN
    tick_div = 2;
    parity_en = 1'b0;
    double_stop = 1'b0;
    re_cnt = 0;
    break_req = 1'b1;
    push(8'h5A);
    begin
      int t = 0;
      while (t < 40) begin
        @(negedge clk);
        #2;
        if (bit_tick) t++;
      end
    end
    chk("brk_no_pop", 32'(re_cnt), 32'd0);
    chk("brk_line", 32'(tx_out_sel), 32'h0);
    break_req = 1'b0;
    wait_idle(200);
    chk("brk_pop", 32'(re_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
